// File: rtl/mem_hs_ctrl_pkg.sv
// mem_hs_ctrl_pkg: shared size defaults, FSM encoding and the byte-merge helper.
package mem_hs_ctrl_pkg;
    localparam int DEPTH_DEF = 16;
    localparam int WIDTH_DEF = 16;
    localparam int MERGE_W = 512;
    localparam int MERGE_BE = MERGE_W / 8;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    // Generic-width merge; callers widen their operands to MERGE_W and truncate the result.
    function automatic logic [MERGE_W-1:0] merge_bytes(
        input logic [MERGE_W-1:0]  old_w,
        input logic [MERGE_W-1:0]  new_w,
        input logic [MERGE_BE-1:0] be
    );
        logic [MERGE_W-1:0] m;
        for (int k = 0; k < MERGE_BE; k++) m[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        return m;
    endfunction
endpackage

// File: rtl/mem_hs_array.sv
// mem_hs_array: word storage with one write port and a combinational read port;
// defining MEM_PARITY_EN adds one even-parity bit per word.
module mem_hs_array #(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0]      i_wdata,
    output logic [WIDTH-1:0]      o_rdata,
    output logic                  o_perr
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_in_range;

    assign w_in_range = 32'(i_addr) < DEPTH;

    always_ff @(posedge clk)
        if (i_we && w_in_range) r_mem[i_addr] <= i_wdata;

    assign o_rdata = w_in_range ? r_mem[i_addr] : '0;

`ifdef MEM_PARITY_EN
    logic [DEPTH-1:0] r_par;

    always_ff @(posedge clk)
        if (i_we && w_in_range) r_par[i_addr] <= ^i_wdata;

    assign o_perr = w_in_range && (r_par[i_addr] ^ (^r_mem[i_addr]));
`else
    assign o_perr = 1'b0;
`endif
endmodule

// File: rtl/mem_hs_ctrl.sv
// mem_hs_ctrl: handshaked single-port memory with byte enables, post-reset clear and
// out-of-range error; MEM_PARITY_EN adds per-word parity checking on reads.
import mem_hs_ctrl_pkg::*;

module mem_hs_ctrl #(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int BE_WIDTH   = WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [WIDTH-1:0]      req_wdata_i,
    input  logic [BE_WIDTH-1:0]   req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [WIDTH-1:0]      rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  init_done_o
);
    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  w_in_range, w_accept, w_rd_acc, w_we, w_perr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [WIDTH-1:0]      w_wdata, w_rdata;

    always_ff @(posedge clk)
        if (rst) r_state <= ST_INIT;
        else     r_state <= w_next;

    always_comb
        w_next = (r_state == ST_INIT && r_clr_cnt == ADDR_WIDTH'(DEPTH - 1)) ? ST_RUN : r_state;

    always_comb begin
        req_ready_o = (r_state == ST_RUN) && (!rsp_valid_o || rsp_ready_i);
        init_done_o = r_state == ST_RUN;
    end

    always_ff @(posedge clk)
        if (rst)                     r_clr_cnt <= '0;
        else if (r_state == ST_INIT) r_clr_cnt <= r_clr_cnt + 1'b1;

    assign w_in_range = 32'(req_addr_i) < DEPTH;
    assign w_accept   = req_valid_i && req_ready_o;
    assign w_rd_acc   = w_accept && !req_we_i;

    // The single port is owned by the clear sequence during INIT, by the request otherwise.
    assign w_we    = !rst && (r_state == ST_INIT || (w_accept && req_we_i && w_in_range));
    assign w_addr  = (r_state == ST_INIT) ? r_clr_cnt : req_addr_i;
    assign w_wdata = (r_state == ST_INIT) ? '0 :
                     WIDTH'(merge_bytes(MERGE_W'(w_rdata), MERGE_W'(req_wdata_i), MERGE_BE'(req_be_i)));

    mem_hs_array #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_arr (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_perr  (w_perr)
    );

    always_ff @(posedge clk)
        if (rst) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else if (w_rd_acc) begin
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= w_rdata;
            rsp_err_o   <= !w_in_range || w_perr;
        end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
endmodule

// File: tb/tb_mem_hs_ctrl.sv
// tb_mem_hs_ctrl: randomized self-checking bench against an array-based memory model (DEPTH=12).
module tb_mem_hs_ctrl;
    localparam int DEPTH = 12;
    localparam int WIDTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = WIDTH / 8;

    logic             clk = 1'b0, rst = 1'b1;
    logic             req_valid_i = 1'b0, req_we_i = 1'b0, rsp_ready_i = 1'b0;
    logic [AW-1:0]    req_addr_i = '0;
    logic [WIDTH-1:0] req_wdata_i = '0;
    logic [BW-1:0]    req_be_i = '0;
    logic             req_ready_o, rsp_valid_o, rsp_err_o, init_done_o;
    logic [WIDTH-1:0] rsp_rdata_o;

    int n_pass = 0, n_total = 0;
    logic [WIDTH-1:0] model [DEPTH];

    always #5 clk = ~clk;

    mem_hs_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .init_done_o (init_done_o)
    );

    function automatic void model_write(input int a, input logic [WIDTH-1:0] d, input logic [BW-1:0] be);
        if (a < DEPTH)
            for (int k = 0; k < BW; k++) if (be[k]) model[a][8*k +: 8] = d[8*k +: 8];
    endfunction

    function automatic logic [WIDTH-1:0] exp_rd(input int a);
        return (a < DEPTH) ? model[a] : '0;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string who);
        int n = 0;
        while (!req_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready_o) begin
            n_total++;
            $display("FAIL %s_timeout: req_ready_o=0 after %0d cycles, need 1", who, n);
        end
    endtask

    task automatic do_write(input int a, input logic [WIDTH-1:0] d, input logic [BW-1:0] be);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = AW'(a); req_wdata_i = d; req_be_i = be;
        wait_ready("wr");
        tick();
        model_write(a, d, be);
        req_valid_i = 1'b0;
    endtask

    task automatic do_read(input int a, output logic v, output logic [WIDTH-1:0] d, output logic e);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = AW'(a);
        req_wdata_i = WIDTH'($urandom); req_be_i = BW'($urandom);
        wait_ready("rd");
        tick();
        v = rsp_valid_o; d = rsp_rdata_o; e = rsp_err_o;
        req_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        int n = 0, bad = 0;
        logic v, e;
        logic [WIDTH-1:0] d;
        rst = 1'b1;
        tick();
        n_total++;
        if ({req_ready_o, rsp_valid_o, rsp_err_o, init_done_o} !== 4'b0 || rsp_rdata_o !== '0)
            $display("FAIL reset_outputs: ready/valid/err/done=%b%b%b%b data=%h, need 0000 0000",
                     req_ready_o, rsp_valid_o, rsp_err_o, init_done_o, rsp_rdata_o);
        else n_pass++;
        tick();
        rst = 1'b0;
        while (!init_done_o && n < 100) begin
            if (req_ready_o !== 1'b0) bad++;
            tick();
            n++;
        end
        n_total++;
        if (n != DEPTH) $display("FAIL init_latency: init_done after %0d edges, need %0d", n, DEPTH);
        else n_pass++;
        n_total++;
        if (bad != 0) $display("FAIL init_ready: req_ready_o high in %0d INIT cycles, need 0", bad);
        else n_pass++;
        model_clear();
        rsp_ready_i = 1'b1;
        do_read(5, v, d, e);
        n_total++;
        if (v !== 1'b1 || d !== 16'h0000 || e !== 1'b0)
            $display("FAIL init_read5: valid=%b data=%h err=%b, need 1 0000 0", v, d, e);
        else n_pass++;
    endtask

    task automatic test_byte_enable();
        logic v, e;
        logic [WIDTH-1:0] d, wd;
        int a;
        logic [BW-1:0] be;
        rsp_ready_i = 1'b1;
        do_write(3, 16'hABCD, 2'b11);
        do_write(3, 16'h12FF, 2'b01);
        do_read(3, v, d, e);
        n_total++;
        if (v !== 1'b1 || d !== 16'hABFF || e !== 1'b0)
            $display("FAIL be_addr3: valid=%b data=%h err=%b, need 1 abff 0", v, d, e);
        else n_pass++;
        repeat (16) begin
            a = $urandom_range(DEPTH - 1);
            wd = WIDTH'($urandom);
            be = BW'($urandom);
            do_write(a, wd, be);
            do_read(a, v, d, e);
            n_total++;
            if (v !== 1'b1 || d !== exp_rd(a) || e !== 1'b0)
                $display("FAIL be_rand_%0d: valid=%b data=%h err=%b, need 1 %h 0", a, v, d, e, exp_rd(a));
            else n_pass++;
        end
        do_write(3, 16'hABFF, 2'b11);
    endtask

    task automatic test_backpressure();
        logic v, e;
        logic [WIDTH-1:0] d;
        rsp_ready_i = 1'b1;
        do_write(7, 16'h7777, 2'b11);
        rsp_ready_i = 1'b0;
        do_read(3, v, d, e);
        n_total++;
        if (v !== 1'b1 || d !== 16'hABFF || e !== 1'b0)
            $display("FAIL bp_first: valid=%b data=%h err=%b, need 1 abff 0", v, d, e);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            req_valid_i = 1'b1;
            req_we_i = (i < 2);
            req_addr_i = (i < 2) ? AW'(3) : AW'(7);
            req_wdata_i = 16'h0000;
            req_be_i = 2'b11;
            n_total++;
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 16'hABFF || rsp_err_o !== 1'b0 || req_ready_o !== 1'b0)
                $display("FAIL bp_hold_%0d: valid=%b data=%h err=%b ready=%b, need 1 abff 0 0",
                         i, rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o);
            else n_pass++;
            tick();
        end
        rsp_ready_i = 1'b1;
        #1;
        n_total++;
        if (req_ready_o !== 1'b1) $display("FAIL bp_release_ready: req_ready_o=%b, need 1", req_ready_o);
        else n_pass++;
        tick();
        req_valid_i = 1'b0;
        n_total++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== exp_rd(7) || rsp_err_o !== 1'b0)
            $display("FAIL bp_next_read: valid=%b data=%h err=%b, need 1 %h 0",
                     rsp_valid_o, rsp_rdata_o, rsp_err_o, exp_rd(7));
        else n_pass++;
        do_read(3, v, d, e);
        n_total++;
        if (v !== 1'b1 || d !== 16'hABFF) $display("FAIL bp_write_blocked: data=%h, need abff", d);
        else n_pass++;
    endtask

    task automatic test_streaming();
        rsp_ready_i = 1'b1;
        for (int a = 0; a < DEPTH; a++) do_write(a, WIDTH'(a * 16'h0101), 2'b11);
        req_valid_i = 1'b1;
        req_we_i = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            req_addr_i = AW'(a);
            n_total++;
            if (req_ready_o !== 1'b1) $display("FAIL stream_ready_%0d: req_ready_o=%b, need 1", a, req_ready_o);
            else n_pass++;
            tick();
            n_total++;
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== exp_rd(a) || rsp_err_o !== 1'b0)
                $display("FAIL stream_rsp_%0d: valid=%b data=%h err=%b, need 1 %h 0",
                         a, rsp_valid_o, rsp_rdata_o, rsp_err_o, exp_rd(a));
            else n_pass++;
        end
        req_valid_i = 1'b0;
        tick();
        n_total++;
        if (rsp_valid_o !== 1'b0) $display("FAIL stream_drain: rsp_valid_o=%b, need 0", rsp_valid_o);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic v, e;
        logic [WIDTH-1:0] d;
        rsp_ready_i = 1'b1;
        do_write(13, 16'h5555, 2'b11);
        do_read(13, v, d, e);
        n_total++;
        if (v !== 1'b1 || d !== 16'h0000 || e !== 1'b1)
            $display("FAIL oor_13: valid=%b data=%h err=%b, need 1 0000 1", v, d, e);
        else n_pass++;
        for (int a = DEPTH; a < (1 << AW); a++) begin
            do_write(a, WIDTH'($urandom), 2'b11);
            do_read(a, v, d, e);
            n_total++;
            if (v !== 1'b1 || d !== 16'h0000 || e !== 1'b1)
                $display("FAIL oor_%0d: valid=%b data=%h err=%b, need 1 0000 1", a, v, d, e);
            else n_pass++;
        end
        for (int a = 0; a < DEPTH; a++) begin
            do_read(a, v, d, e);
            n_total++;
            if (v !== 1'b1 || d !== exp_rd(a) || e !== 1'b0)
                $display("FAIL oor_keep_%0d: valid=%b data=%h err=%b, need 1 %h 0", a, v, d, e, exp_rd(a));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic v, e;
        logic [WIDTH-1:0] d;
        int a;
        rsp_ready_i = 1'b1;
        repeat (30) begin
            a = $urandom_range((1 << AW) - 1);
            do_write(a, WIDTH'($urandom), BW'($urandom));
            do_read(a, v, d, e);
            n_total++;
            if (v !== 1'b1 || d !== exp_rd(a) || e !== (a >= DEPTH))
                $display("FAIL b2b_%0d: valid=%b data=%h err=%b, need 1 %h %b", a, v, d, e, exp_rd(a), a >= DEPTH);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        logic v, e;
        logic [WIDTH-1:0] d;
        rsp_ready_i = 1'b1;
        do_write(4, 16'hC3C3, 2'b11);
        rsp_ready_i = 1'b0;
        do_read(4, v, d, e);
        n_total++;
        if (v !== 1'b1 || d !== 16'hC3C3) $display("FAIL mid_pending: valid=%b data=%h, need 1 c3c3", v, d);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0 || init_done_o !== 1'b0)
            $display("FAIL mid_rst_state: valid=%b ready=%b done=%b, need 0 0 0", rsp_valid_o, req_ready_o, init_done_o);
        else n_pass++;
        while (!init_done_o && n < 100) begin
            tick();
            n++;
        end
        n_total++;
        if (n != DEPTH) $display("FAIL mid_reinit: init_done after %0d edges, need %0d", n, DEPTH);
        else n_pass++;
        model_clear();
        rsp_ready_i = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            do_read(a, v, d, e);
            n_total++;
            if (v !== 1'b1 || d !== 16'h0000 || e !== 1'b0)
                $display("FAIL mid_cleared_%0d: valid=%b data=%h err=%b, need 1 0000 0", a, v, d, e);
            else n_pass++;
        end
`ifdef MEM_PARITY_EN
        force dut.u_arr.r_par[2] = 1'b1;
        do_read(2, v, d, e);
        release dut.u_arr.r_par[2];
        n_total++;
        if (v !== 1'b1 || e !== 1'b1) $display("FAIL parity_flip: valid=%b err=%b, need 1 1", v, e);
        else n_pass++;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_byte_enable();
        test_backpressure();
        test_streaming();
        test_out_of_range();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_hs_ctrl.md
Name: mem_hs_ctrl

Overview:
- Parametrised single-port synchronous memory with a proper request/response valid-ready handshake, byte-enable writes and a hardware clear sequence after reset.
- Successor to the fixed 16x16 memory. Adds:
  - response backpressure;
  - a registered one-cycle read response;
  - byte lanes;
  - out-of-range address detection.
- Sits between a bus master or testbench driver and local storage.

Parameters:
- DEPTH, 16, number of words; need not be a power of 2.
- WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, $clog2(DEPTH), address width (derived; do not override).
- BE_WIDTH, WIDTH/8, byte-enable width (derived).

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- req_valid_i  input  1  request present
- req_ready_o  output  1  request accepted this cycle when high together with req_valid_i
- req_we_i  input  1  1 = write, 0 = read
- req_addr_i  input  ADDR_WIDTH  word address
- req_wdata_i  input  WIDTH  write data
- req_be_i  input  BE_WIDTH  byte enables; bit k controls bits [8k+7:8k]
- rsp_valid_o  output  1  read response valid
- rsp_ready_i  input  1  consumer accepts response
- rsp_rdata_o  output  WIDTH  read data
- rsp_err_o  output  1  response error flag, qualified by rsp_valid_o
- init_done_o  output  1  clear sequence complete

Behaviour:
- FSM states: INIT, RUN.
- Reset:
  - rst sampled high forces state=INIT and clr_cnt=0.
  - Outputs: req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, init_done_o=0.
  - Memory contents are not touched during the rst cycle.
- INIT:
  - Each clock with rst low writes mem[clr_cnt]=0 and increments clr_cnt.
  - After mem[DEPTH-1] is written, state goes to RUN.
  - init_done_o=1 from the cycle after the last clear write, i.e. DEPTH edges after rst deasserts.
  - req_ready_o=0 throughout INIT.
- RUN:
  - req_ready_o = !rsp_valid_o || rsp_ready_i. This is combinational; a response slot is free or being freed.
  - Request accepted on an edge where req_valid_i && req_ready_o.
- Accepted write:
  - For each k with req_be_i[k]=1, mem[addr] byte k = req_wdata_i byte k. Other bytes are unchanged.
  - No response is generated.
  - be=0 is a legal no-op.
- Accepted read:
  - On the same edge, rsp_rdata_o<=mem[addr] and rsp_valid_o<=1.
  - Latency is 1 cycle from acceptance to valid.
- Response hold:
  - While rsp_valid_o && !rsp_ready_i, rsp_rdata_o and rsp_err_o hold stable.
  - No new request is accepted, reads and writes alike.
- Response clear: when rsp_valid_o && rsp_ready_i and no read is accepted on that edge, rsp_valid_o<=0 and data holds its last value.
- Back-to-back reads with rsp_ready_i=1 held high give one response per cycle.
- Write-then-read to the same address on consecutive cycles: the read returns the new data.
- Out of range (addr >= DEPTH, possible only if DEPTH is not a power of 2):
  - A write is dropped.
  - A read returns rsp_rdata_o=0 with rsp_err_o=1.
  - In-range reads give rsp_err_o=0.
- Reset mid-operation: any pending response is discarded (rsp_valid_o=0) and the clear sequence restarts from address 0.
- X-safety: req_* inputs are ignored when req_valid_i=0.

Optional Feature:
- MEM_PARITY_EN defined:
  - Each word stores one extra even-parity bit, computed over the final merged word on every write, including clear writes.
  - On a read, the parity mismatch is ORed into rsp_err_o.
  - A debug-only input is not added; the bench corrupts parity via hierarchical force on the parity array.
- Not defined: no parity storage; rsp_err_o reflects out-of-range only.

Decomposition:
- Shared package/include (common.v style): `DEPTH/`WIDTH defaults, FSM state encodings ST_INIT=1'b0, ST_RUN=1'b1, and the byte-merge helper function.
- Sub-module mem_hs_array: the storage array plus optional parity bits.
  - Interface: one write port (addr, merged data, we) and a combinational read port.
  - All handshake, FSM and response logic lives in the top module.

Test Plan:
- Reset/init: assert rst 2 cycles, release. Required: init_done_o=1 exactly 16 edges later, req_ready_o=0 until then, and a read of addr 5 returns 0x0000 with err=0.
- Byte-enable write: write 0xABCD to addr 3 with be=2'b11, then 0x12FF with be=2'b01. Read addr 3 returns 0xABFF one cycle after acceptance.
- Backpressure: read addr 3 with rsp_ready_i=0 for 4 cycles. Required:
  - rsp_valid_o stays 1 and rsp_rdata_o stable at 0xABFF;
  - req_ready_o=0;
  - when rsp_ready_i=1, req_ready_o rises combinationally and the next read is accepted the same edge.
- Streaming: rsp_ready_i=1, reads to addr 0..15 on consecutive cycles after writing data=addr*0x0101. Required: 16 consecutive responses in order, no bubbles.
- Out of range: with DEPTH=12, write 0x5555 to addr 13, then read addr 13. Required: rsp_rdata_o=0, rsp_err_o=1; addr 0..11 are unchanged.
- Mid-op reset: a read is pending with rsp_ready_i=0, then rst is pulsed. Required:
  - rsp_valid_o=0 next cycle;
  - the clear sequence repeats over DEPTH cycles;
  - previously written addresses read 0.
  - With MEM_PARITY_EN defined, a forced parity flip on addr 2 gives rsp_err_o=1.
